// File: rtl/wb_regfile_pkg.sv
// Shared sizing defaults and the jal link register index for the writeback stage.
package wb_regfile_pkg;

  localparam int unsigned DefDsize = 32;
  localparam int unsigned DefAsize = 5;
  localparam int unsigned DefIsize = 32;

  // Architectural return-address register written by jal.
  localparam int unsigned JalReg = 31;

endpackage

// File: rtl/wb_regfile_mux.sv
// Writeback value select: jal return address, load data or ALU result.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DSIZE = DefDsize,
  parameter int unsigned ISIZE = DefIsize
) (
  input  logic [DSIZE-1:0] data_out,
  input  logic [DSIZE-1:0] aluout,
  input  logic [ISIZE-1:0] pcout,
  input  logic             memtoreg,
  input  logic             jal,
  output logic [DSIZE-1:0] wb_data
);

  always_comb begin
    wb_data = aluout;
    if (jal) begin
      // Return address is already final; only width-adjust it.
      wb_data = DSIZE'(pcout);
    end else if (memtoreg) begin
      wb_data = data_out;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and register file with same-cycle write-to-read bypass.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DSIZE = DefDsize,
  parameter int unsigned ASIZE = DefAsize,
  parameter int unsigned ISIZE = DefIsize
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] data_out_in,
  input  logic [DSIZE-1:0] aluout_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  input  logic             memtoreg_in,
  input  logic             jal_in,
  input  logic [ISIZE-1:0] PCOUT_in,
  input  logic [ASIZE-1:0] raddr1,
  input  logic [ASIZE-1:0] raddr2,
  output logic [DSIZE-1:0] rdata1,
  output logic [DSIZE-1:0] rdata2,
  output logic [DSIZE-1:0] wb_data,
  output logic [ASIZE-1:0] wb_waddr,
  output logic             wb_valid
);

  localparam int unsigned Depth = 2 ** ASIZE;

  logic [DSIZE-1:0] regs_q [Depth];

  wb_mux #(
    .DSIZE (DSIZE),
    .ISIZE (ISIZE)
  ) u_wb_mux (
    .data_out (data_out_in),
    .aluout   (aluout_in),
    .pcout    (PCOUT_in),
    .memtoreg (memtoreg_in),
    .jal      (jal_in),
    .wb_data  (wb_data)
  );

  assign wb_waddr = jal_in ? ASIZE'(JalReg) : waddr_in;
  assign wb_valid = (wen_in | jal_in) & (wb_waddr != '0);

  // Register 0 is never written because wb_valid excludes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_valid) begin
      regs_q[wb_waddr] <= wb_data;
    end
  end

  always_comb begin
    rdata1 = regs_q[raddr1];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (wb_valid && (raddr1 == wb_waddr)) begin
      rdata1 = wb_data;
    end
  end

  always_comb begin
    rdata2 = regs_q[raddr2];
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (wb_valid && (raddr2 == wb_waddr)) begin
      rdata2 = wb_data;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases plus randomized traffic vs. an array model.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] data_out_in;
  logic [31:0] aluout_in;
  logic [4:0]  waddr_in;
  logic        wen_in;
  logic        memtoreg_in;
  logic        jal_in;
  logic [31:0] PCOUT_in;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] wb_data;
  logic [4:0]  wb_waddr;
  logic        wb_valid;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] model [32];

  wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .data_out_in (data_out_in),
    .aluout_in   (aluout_in),
    .waddr_in    (waddr_in),
    .wen_in      (wen_in),
    .memtoreg_in (memtoreg_in),
    .jal_in      (jal_in),
    .PCOUT_in    (PCOUT_in),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .wb_data     (wb_data),
    .wb_waddr    (wb_waddr),
    .wb_valid    (wb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic v,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (v && a == wa) return wd;
    return model[a];
  endfunction

  task automatic drive(input logic wen, input logic jal, input logic m2r, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [31:0] dout, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2);
    wen_in = wen; jal_in = jal; memtoreg_in = m2r; waddr_in = wa;
    aluout_in = alu; data_out_in = dout; PCOUT_in = pc; raddr1 = r1; raddr2 = r2;
  endtask

  // Check every output against the model at negedge, then commit to the model and cross the edge.
  task automatic step();
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        v;
    @(negedge clk);
    wd = jal_in ? PCOUT_in : (memtoreg_in ? data_out_in : aluout_in);
    wa = jal_in ? 5'd31 : waddr_in;
    v  = (wen_in || jal_in) && (wa != 5'd0);
    check_eq("wb_data", wb_data, wd);
    check_eq("wb_waddr", {27'd0, wb_waddr}, {27'd0, wa});
    check_eq("wb_valid", {31'd0, wb_valid}, {31'd0, v});
    check_eq("rdata1", rdata1, model_read(raddr1, v, wa, wd));
    check_eq("rdata2", rdata2, model_read(raddr2, v, wa, wd));
    if (v && !rst) model[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    // Write presented while in reset: bypass visible, but the edge is lost.
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd4, 32'h55, 32'h0, 32'h0, 5'd4, 5'd0);
    #1;
    check_eq("rst_bypass", rdata1, 32'h55);
    check_eq("rst_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("rst_r0", rdata2, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    wen_in = 1'b0;
    #1;
    check_eq("rst_lost_write", rdata1, 32'd0);

    // First edge after reset release accepts a write.
    drive(1'b1, 1'b0, 1'b0, 5'd4, 32'h66, 32'h0, 32'h0, 5'd4, 5'd1);
    step();
    wen_in = 1'b0;
    #1;
    check_eq("post_rst_write", rdata1, 32'h66);

    // ALU write with bypass, then hold.
    drive(1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h0, 5'd5, 5'd4);
    #1;
    check_eq("alu_bypass", rdata1, 32'h1234);
    step();
    wen_in = 1'b0;
    #1;
    check_eq("alu_stored", rdata1, 32'h1234);

    // Load write selects memory data, not the ALU result.
    drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h1, 32'hDEADBEEF, 32'h0, 5'd7, 5'd5);
    step();
    wen_in = 1'b0;
    #1;
    check_eq("load_stored", rdata1, 32'hDEADBEEF);

    // jal writes r31 ignoring waddr and wen; r3 keeps its prior value.
    drive(1'b1, 1'b0, 1'b0, 5'd3, 32'h33, 32'h0, 32'h0, 5'd3, 5'd0);
    step();
    drive(1'b0, 1'b1, 1'b1, 5'd3, 32'h77, 32'h88, 32'h00400008, 5'd31, 5'd3);
    #1;
    check_eq("jal_waddr", {27'd0, wb_waddr}, 32'd31);
    check_eq("jal_bypass", rdata1, 32'h00400008);
    step();
    jal_in = 1'b0;
    #1;
    check_eq("jal_r31", rdata1, 32'h00400008);
    check_eq("jal_r3_kept", rdata2, 32'h33);

    // Writes to $0 are discarded.
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    check_eq("r0_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("r0_before", rdata1, 32'd0);
    step();
    check_eq("r0_after", rdata1, 32'd0);

    // Both ports bypass together.
    drive(1'b1, 1'b0, 1'b0, 5'd9, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd9, 5'd9);
    #1;
    check_eq("dual_bypass1", rdata1, 32'hA5A5A5A5);
    check_eq("dual_bypass2", rdata2, 32'hA5A5A5A5);
    step();

    // Asynchronous reset mid-cycle clears everything before the next edge.
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd7);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_r5", rdata1, 32'd0);
    check_eq("async_r7", rdata2, 32'd0);
    raddr1 = 5'd9;
    raddr2 = 5'd31;
    #1;
    check_eq("async_r9", rdata1, 32'd0);
    check_eq("async_r31", rdata2, 32'd0);
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
            wa, $urandom, $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
